// File: rtl/sdf_tw_mult_pkg.sv
// sdf_tw_mult_pkg: shared constants and types for the SDF twiddle-multiply stage.
//   DATA_IN_WIDTH     sample / twiddle width W (twiddle 1.0 = 2^(W-2))
//   FFT_POINTS        transform length N
//   C2LOG_FFT_POINTS  log2(N), also the twiddle address width
//   TW_FRAC_BITS      twiddle scale shift (W-2)
//   TW_RND_CONST      half-LSB rounding constant added before the shift
package sdf_tw_mult_pkg;

    localparam int DATA_IN_WIDTH    = 16;
    localparam int FFT_POINTS       = 16;
    localparam int C2LOG_FFT_POINTS = 4;
    localparam int TW_FRAC_BITS     = DATA_IN_WIDTH - 2;
    localparam int TW_RND_CONST     = 1 << (TW_FRAC_BITS - 1);

    typedef logic signed [DATA_IN_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sdf_tw_mult_cmult.sv
// sdf_tw_mult_cmult: three-stage pipelined complex multiplier (a+jb)(c+jd)
// with half-up rounding, Q(W-2) rescale and W-bit reduction.
// Optional macro TW_MULT_SAT_EN: saturate the result instead of wrapping.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en_i                input valid
//   a_re_i, a_im_i      sample (a, b)
//   tw_re_i, tw_im_i    twiddle (c, d)
//   en_o                output valid, three cycles after en_i
//   re_o, im_o          rounded product, held while en_o = 0
module sdf_tw_mult_cmult
    import sdf_tw_mult_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en_i,
    input  sample_t a_re_i,
    input  sample_t a_im_i,
    input  sample_t tw_re_i,
    input  sample_t tw_im_i,
    output logic    en_o,
    output sample_t re_o,
    output sample_t im_o
);

    localparam int W  = DATA_IN_WIDTH;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;
    localparam logic signed [SW-1:0] RND = SW'(TW_RND_CONST);
`ifdef TW_MULT_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = $signed({{(W+2){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({{(W+2){1'b1}}, {(W-1){1'b0}}});
`endif

    function automatic logic signed [PW-1:0] sext_w(input sample_t x);
        return {{W{x[W-1]}}, x};
    endfunction

    // Round half-up, drop the twiddle fraction bits, then fit to W bits.
    function automatic sample_t round_reduce(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] r;
        r = (x + RND) >>> TW_FRAC_BITS;
`ifdef TW_MULT_SAT_EN
        if (r > SAT_MAX)      return SAT_MAX[W-1:0];
        else if (r < SAT_MIN) return SAT_MIN[W-1:0];
        else                  return r[W-1:0];
`else
        return r[W-1:0];
`endif
    endfunction

    logic signed [PW-1:0] ac_p0_q, bd_p0_q, ad_p0_q, bc_p0_q;
    logic                 vld_p0_q;
    logic signed [SW-1:0] re_p1_q, im_p1_q;
    logic                 vld_p1_q;
    sample_t              re_p2_q, im_p2_q;
    logic                 vld_p2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_p0_q  <= '0;
            bd_p0_q  <= '0;
            ad_p0_q  <= '0;
            bc_p0_q  <= '0;
            vld_p0_q <= 1'b0;
            re_p1_q  <= '0;
            im_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            re_p2_q  <= '0;
            im_p2_q  <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            // Stage 1: four partial products
            vld_p0_q <= en_i;
            if (en_i) begin
                ac_p0_q <= sext_w(a_re_i) * sext_w(tw_re_i);
                bd_p0_q <= sext_w(a_im_i) * sext_w(tw_im_i);
                ad_p0_q <= sext_w(a_re_i) * sext_w(tw_im_i);
                bc_p0_q <= sext_w(a_im_i) * sext_w(tw_re_i);
            end
            // Stage 2: real/imag sums, one guard bit
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) begin
                re_p1_q <= {ac_p0_q[PW-1], ac_p0_q} - {bd_p0_q[PW-1], bd_p0_q};
                im_p1_q <= {ad_p0_q[PW-1], ad_p0_q} + {bc_p0_q[PW-1], bc_p0_q};
            end
            // Stage 3: round and reduce; output holds between valid samples
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                re_p2_q <= round_reduce(re_p1_q);
                im_p2_q <= round_reduce(im_p1_q);
            end
        end
    end

    assign en_o = vld_p2_q;
    assign re_o = re_p2_q;
    assign im_o = im_p2_q;

endmodule

// File: rtl/sdf_tw_mult.sv
// sdf_tw_mult: twiddle-multiply stage following a radix-2 SDF butterfly.
// Counts valid samples within the stage's P = N>>STAGE block, emits the
// twiddle-table address, delays the sample TW_FF cycles to meet the table
// output, and multiplies through sdf_tw_mult_cmult. Latency TW_FF+3.
// Optional macro TW_MULT_SAT_EN: saturate products instead of wrapping.
// Parameters: STAGE (0..C2LOG_FFT_POINTS-1), TW_FF (table latency, 0 or 1).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   di_en             input sample valid
//   di_re, di_im      input sample
//   tw_addr           twiddle address, combinational from the counter
//   tw_re, tw_im      twiddle from the table, TW_FF cycles after tw_addr
//   do_en             output valid
//   do_re, do_im      product, held while do_en = 0
module sdf_tw_mult
    import sdf_tw_mult_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int TW_FF = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        di_en,
    input  logic signed [DATA_IN_WIDTH-1:0] di_re,
    input  logic signed [DATA_IN_WIDTH-1:0] di_im,
    output logic [C2LOG_FFT_POINTS-1:0] tw_addr,
    input  logic signed [DATA_IN_WIDTH-1:0] tw_re,
    input  logic signed [DATA_IN_WIDTH-1:0] tw_im,
    output logic                        do_en,
    output logic signed [DATA_IN_WIDTH-1:0] do_re,
    output logic signed [DATA_IN_WIDTH-1:0] do_im
);

    localparam int CNT_W = C2LOG_FFT_POINTS - STAGE;
    localparam int P     = FFT_POINTS >> STAGE;
    localparam int H     = P / 2;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [C2LOG_FFT_POINTS-1:0] k_ext;

    // P is a power of two, so natural counter overflow is the P-1 -> 0 wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (di_en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // First half of each block uses W^0 (address 0); second half walks k<<STAGE.
    assign k_ext   = C2LOG_FFT_POINTS'(cnt_q) & C2LOG_FFT_POINTS'(H - 1);
    assign tw_addr = cnt_q[CNT_W-1] ? (k_ext << STAGE) : '0;

    sample_t mul_re, mul_im;
    logic    mul_en;

    generate
        if (TW_FF == 1) begin : g_align
            always_ff @(posedge clk) begin
                if (rst) begin
                    mul_en <= 1'b0;
                    mul_re <= '0;
                    mul_im <= '0;
                end else begin
                    mul_en <= di_en;
                    if (di_en) begin
                        mul_re <= di_re;
                        mul_im <= di_im;
                    end
                end
            end
        end else begin : g_noalign
            assign mul_en = di_en;
            assign mul_re = di_re;
            assign mul_im = di_im;
        end
    endgenerate

    sdf_tw_mult_cmult u_cmult (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mul_en),
        .a_re_i  (mul_re),
        .a_im_i  (mul_im),
        .tw_re_i (tw_re),
        .tw_im_i (tw_im),
        .en_o    (do_en),
        .re_o    (do_re),
        .im_o    (do_im)
    );

endmodule

// File: tb/tb_sdf_tw_mult.sv
// Directed bench for sdf_tw_mult: W=16, N=16, TW_FF=1, STAGE 0 and 1 instances
// sharing data and reset, each with its own one-cycle twiddle table.
module tb_sdf_tw_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                di_en0, di_en1;
    logic signed [15:0]  di_re, di_im;
    logic [3:0]          tw_addr0, tw_addr1;
    logic signed [15:0]  tw_re0, tw_im0, tw_re1, tw_im1;
    logic                do_en0, do_en1;
    logic signed [15:0]  do_re0, do_im0, do_re1, do_im1;

    int n_checks = 0;
    int n_errors = 0;

`ifdef TW_MULT_SAT_EN
    localparam int OVF_IM = 32767;
`else
    localparam int OVF_IM = -32768;
`endif

    // round(2^14 * exp(-j*2*pi*k/16))
    int tw_re_tab [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                           -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};
    int tw_im_tab [16] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270,
                           0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

    always @(posedge clk) begin
        tw_re0 <= 16'(tw_re_tab[tw_addr0]);
        tw_im0 <= 16'(tw_im_tab[tw_addr0]);
        tw_re1 <= 16'(tw_re_tab[tw_addr1]);
        tw_im1 <= 16'(tw_im_tab[tw_addr1]);
    end

    sdf_tw_mult #(.STAGE(0), .TW_FF(1)) dut0 (
        .clk(clk), .rst(rst), .di_en(di_en0), .di_re(di_re), .di_im(di_im),
        .tw_addr(tw_addr0), .tw_re(tw_re0), .tw_im(tw_im0),
        .do_en(do_en0), .do_re(do_re0), .do_im(do_im0)
    );

    sdf_tw_mult #(.STAGE(1), .TW_FF(1)) dut1 (
        .clk(clk), .rst(rst), .di_en(di_en1), .di_re(di_re), .di_im(di_im),
        .tw_addr(tw_addr1), .tw_re(tw_re1), .tw_im(tw_im1),
        .do_en(do_en1), .do_re(do_re1), .do_im(do_im1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int re;
        int im;
        int addr0;
        int addr1;
        int ore;
        int oim;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int   last_re, last_im;
        bit   exp_en [52];
        int   exp_re [52];
        int   exp_im [52];
        int   in_re [52];
        int   in_im [52];
        int   exp_addr [52];

        // {in_re, in_im, addr stage0, addr stage1, out_re, out_im}
        tbl[0]  = '{100,    -200,   0, 0, 100,    -200};
        tbl[1]  = '{-32768, 32767,  0, 0, -32768, 32767};
        tbl[2]  = '{32767,  -32768, 0, 0, 32767,  -32768};
        tbl[3]  = '{0,      0,      0, 0, 0,      0};
        tbl[4]  = '{1,      -1,     0, 0, 1,      -1};
        tbl[5]  = '{-5,     7,      0, 2, -5,     7};
        tbl[6]  = '{12345,  -23456, 0, 4, 12345,  -23456};
        tbl[7]  = '{-1,     1,      0, 6, -1,     1};
        tbl[8]  = '{16384,  0,      0, 0, 16384,  0};
        tbl[9]  = '{0,      16384,  1, 0, 6270,   15137};
        tbl[10] = '{16384,  0,      2, 0, 11585,  -11585};
        tbl[11] = '{0,      16384,  3, 0, 15137,  6270};
        tbl[12] = '{1000,   0,      4, 0, 0,      -1000};
        tbl[13] = '{16384,  0,      5, 2, -6270,  -15137};
        tbl[14] = '{0,      16384,  6, 4, 11585,  -11585};
        tbl[15] = '{-16384, 0,      7, 6, 15137,  6270};

        rst = 1'b1; di_en0 = 1'b0; di_en1 = 1'b0; di_re = '0; di_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_do_en0", int'(do_en0), 0);
        check("rst_do_en1", int'(do_en1), 0);
        check("rst_do_re0", int'(do_re0), 0);
        check("rst_do_im0", int'(do_im0), 0);
        check("rst_addr0", int'(tw_addr0), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back frame on both stages
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            if (c < 16) begin
                di_en0 = 1'b1; di_en1 = 1'b1;
                di_re = 16'(tbl[c].re); di_im = 16'(tbl[c].im);
            end else begin
                di_en0 = 1'b0; di_en1 = 1'b0;
            end
            @(negedge clk);
            if (c < 16) begin
                check($sformatf("t1_addr0[%0d]", c), int'(tw_addr0), tbl[c].addr0);
                check($sformatf("t1_addr1[%0d]", c), int'(tw_addr1), tbl[c].addr1);
            end
            check($sformatf("t1_do_en[%0d]", c), int'(do_en0), (c >= 4 && c < 20) ? 1 : 0);
            if (c >= 4 && c < 20) begin
                check($sformatf("t1_re[%0d]", c - 4), int'(do_re0), tbl[c-4].ore);
                check($sformatf("t1_im[%0d]", c - 4), int'(do_im0), tbl[c-4].oim);
            end else if (c == 20) begin
                check("t1_hold_re", int'(do_re0), tbl[15].ore);
                check("t1_hold_im", int'(do_im0), tbl[15].oim);
            end
        end

        // Overflow at address 4: (-32768,0)*(0,-1.0)
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            di_en0 = (c < 16);
            di_re  = (c == 12) ? -16'sd32768 : 16'sd0;
            di_im  = '0;
            @(negedge clk);
            if (c == 12) check("t2_addr", int'(tw_addr0), 4);
            if (c == 16) begin
                check("t2_do_en", int'(do_en0), 1);
                check("t2_ovf_re", int'(do_re0), 0);
                check("t2_ovf_im", int'(do_im0), OVF_IM);
            end
        end

        // Gapped input: one valid sample every third cycle
        for (int c = 0; c < 52; c++) begin
            int s;
            s = c / 3;
            exp_en[c] = (c % 3 == 0) && (c < 48);
            if (s < 8) begin
                in_re[c] = s * 100 + 1; in_im[c] = -s * 50;
                exp_re[c] = in_re[c];   exp_im[c] = in_im[c];
                exp_addr[c] = 0;
            end else begin
                in_re[c] = 16384; in_im[c] = 0;
                exp_re[c] = tw_re_tab[s-8]; exp_im[c] = tw_im_tab[s-8];
                exp_addr[c] = s - 8;
            end
        end
        last_re = 0; last_im = 0;
        for (int c = 0; c < 52; c++) begin
            @(posedge clk); #1;
            di_en0 = exp_en[c];
            di_re  = 16'(in_re[c]);
            di_im  = 16'(in_im[c]);
            @(negedge clk);
            if (exp_en[c]) check($sformatf("t3_addr[%0d]", c), int'(tw_addr0), exp_addr[c]);
            if (c >= 4) begin
                check($sformatf("t3_do_en[%0d]", c), int'(do_en0), int'(exp_en[c-4]));
                if (exp_en[c-4]) begin
                    last_re = exp_re[c-4]; last_im = exp_im[c-4];
                end
                check($sformatf("t3_re[%0d]", c), int'(do_re0), last_re);
                check($sformatf("t3_im[%0d]", c), int'(do_im0), last_im);
            end
        end

        // Reset mid-frame with samples in flight; rst wins over di_en
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            rst = (c == 5);
            if (c < 5) begin
                di_en0 = 1'b1; di_en1 = 1'b1;
                di_re = 16'((c + 1) * 11); di_im = 16'(-(c + 1));
            end else if (c == 5) begin
                di_en0 = 1'b1; di_en1 = 1'b1; di_re = 16'sd5555; di_im = 16'sd0;
            end else if (c == 7) begin
                di_en0 = 1'b1; di_en1 = 1'b1; di_re = 16'sd777; di_im = -16'sd333;
            end else begin
                di_en0 = 1'b0; di_en1 = 1'b0;
            end
            @(negedge clk);
            if (c == 4) begin
                check("t4_pre_en", int'(do_en0), 1);
                check("t4_pre_re", int'(do_re0), 11);
            end
            if (c == 5) begin
                check("t4_addr1_pre", int'(tw_addr1), 2);
                check("t4_pre_re1", int'(do_re0), 22);
            end
            if (c >= 6 && c <= 10) begin
                check($sformatf("t4_en0[%0d]", c), int'(do_en0), 0);
                check($sformatf("t4_en1[%0d]", c), int'(do_en1), 0);
                check($sformatf("t4_re0[%0d]", c), int'(do_re0), 0);
                check($sformatf("t4_im0[%0d]", c), int'(do_im0), 0);
            end
            if (c == 7) begin
                check("t4_addr0_post", int'(tw_addr0), 0);
                check("t4_addr1_post", int'(tw_addr1), 0);
            end
            if (c == 11) begin
                check("t4_en0_post", int'(do_en0), 1);
                check("t4_re0_post", int'(do_re0), 777);
                check("t4_im0_post", int'(do_im0), -333);
                check("t4_en1_post", int'(do_en1), 1);
                check("t4_re1_post", int'(do_re1), 777);
            end
            if (c == 12) begin
                check("t4_en0_end", int'(do_en0), 0);
                check("t4_hold_re", int'(do_re0), 777);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdf_tw_mult.md
# sdf_tw_mult

Twiddle-multiply stage of the R2SDF FFT pipeline. Sits directly downstream of each radix-2 SDF butterfly and directly upstream of the next stage. It generates the per-sample twiddle-table address for its stage, consumes the table's real/imag outputs, and multiplies the butterfly output stream by the twiddle factor through a pipelined, rounded complex multiplier.

## Interface
Parameters:
- STAGE, 0: SDF stage index, 0..`C2LOG_FFT_POINTS-1`.
- TW_FF, 1: twiddle-table read latency in cycles (0 or 1). Must match the table instance.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- di_en  in  1  input sample valid.
- di_re / di_im  in  `DATA_IN_WIDTH` each  input sample, signed.
- tw_addr  out  `C2LOG_FFT_POINTS`  twiddle-table address. Combinational from the counter.
- tw_re / tw_im  in  `DATA_IN_WIDTH` each  twiddle value, signed; 1.0 = 2^(W-2).
- do_en  out  1  output valid.
- do_re / do_im  out  `DATA_IN_WIDTH` each  product, signed.

## Operation
Notation: W = `DATA_IN_WIDTH`, N = `FFT_POINTS`, P = N>>STAGE, H = P/2.

Sample counter:
- cnt has log2(P) bits. It advances by 1 only on cycles with di_en=1, and wraps from P-1 to 0.
- Gaps in di_en are allowed; cnt holds during gaps.

Address generation:
- k = cnt mod H. half = MSB of cnt.
- tw_addr = half ? (k << STAGE) : 0.
- Address 0 selects W^0 = 1.0, so first-half samples pass through unchanged (exact: a·2^(W-2)>>(W-2) = a).

Data alignment:
- di_re, di_im and di_en are delayed TW_FF cycles so data and twiddle meet at the multiplier input.

Complex multiply (c = tw_re, d = tw_im):
- Stage 1: register the four signed products a·c, b·d, a·d, b·c, each 2W bits.
- Stage 2: register re = ac − bd and im = ad + bc, each 2W+1 bits.
- Stage 3: round half-up by adding 2^(W-3), arithmetic shift right by W-2, then reduce to W bits (see Configuration). Register the results.
- The valid bit travels alongside the data at every stage.

Reset:
- cnt = 0, all valid bits = 0, do_en = 0, do_re = do_im = 0, pipeline data registers = 0.
- A reset mid-frame drops in-flight samples. The next di_en sample is treated as cnt = 0.

## Timing
- Latency: do_en is asserted exactly TW_FF+3 cycles after the corresponding di_en.
- Throughput: one sample per cycle. There is no backpressure.
- do_re and do_im hold their last value while do_en = 0.
- rst takes priority over di_en in the same cycle: the sample is dropped and cnt = 0.
- tw_addr is valid in the same cycle as di_en. The table's output is expected TW_FF cycles later.

## Configuration
- TW_MULT_SAT_EN defined: stage 3 saturates to [−2^(W-1), 2^(W-1)−1].
- Not defined: stage 3 truncates to the low W bits (two's-complement wrap).

## Structure
- W, N and `C2LOG_FFT_POINTS` come from define.v. Add the rounding constant and the twiddle scale shift (W-2) there as `TW_FRAC_BITS`.
- Sub-module: cmult, the three-stage pipelined complex multiplier with round/saturate and valid passthrough. sdf_tw_mult holds the counter, address generation, and the alignment delay.

## Test plan
Bench setup: W = 16, N = 16, TW_FF = 1, table loaded with round(2^14·e^(−j2πk/16)).

- STAGE=0, 16 consecutive samples -> tw_addr sequence 0×8, then 0,1,…,7. First 8 outputs equal their inputs. do_en rises 4 cycles after the first di_en.
- STAGE=1, 16 samples -> tw_addr = 0,0,0,0,0,2,4,6, repeated twice (cnt wraps at 8).
- STAGE=0, sample 12 (addr 4, tw = (0, −16384)), input (1000, 0) -> output (0, −1000).
- Overflow case: input (−32768, 0) at addr 4 -> do_im = 32767 with TW_MULT_SAT_EN, and −32768 without it. do_re = 0 in both builds.
- di_en toggled 1,0,0,1,… for 16 samples -> addresses follow valid samples only. The do_en pattern equals the di_en pattern shifted by 4 cycles.
- rst asserted after the 5th sample with 3 samples in flight -> do_en stays 0 and no stale output appears. The next sample gets tw_addr = 0 and is output unchanged.
